// File: rtl/mrv1_ifetch.sv
// mrv1 instruction fetch: per-thread PCs, round-robin issue of a single outstanding
// imem request, and an in-order instruction queue feeding decode.
module mrv1_ifetch #(
  parameter int unsigned NUM_THREADS_P = 4,
  parameter int unsigned QUEUE_DEPTH_P = 2,
  parameter logic [31:0] BOOT_PC_P     = 32'h0000_0000,
  localparam int unsigned twid_width_lp = (NUM_THREADS_P > 1) ? $clog2(NUM_THREADS_P) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_THREADS_P-1:0] thread_en_i,
  input  logic                     imem_req_rdy_i,
  output logic                     imem_req_vld_o,
  output logic [31:0]              imem_req_addr_o,
  input  logic                     imem_rsp_vld_i,
  input  logic [31:0]              imem_rsp_data_i,
  input  logic                     imem_rsp_err_i,
  input  logic                     decode_rdy_i,
  output logic                     insn_vld_o,
  output logic [31:0]              insn_o,
  output logic [31:0]              insn_pc_o,
  output logic [twid_width_lp-1:0] insn_twid_o,
  output logic                     insn_is_rv16_o,
  output logic                     insn_illegal_o,
  input  logic                     redirect_vld_i,
  input  logic [twid_width_lp-1:0] redirect_twid_i,
  input  logic [31:0]              redirect_pc_i
);
  localparam int unsigned qaw_lp   = $clog2(QUEUE_DEPTH_P);
  localparam int unsigned ptr_w_lp = qaw_lp + 1;

  typedef struct packed {
    logic                     kill;
    logic                     illegal;
    logic [twid_width_lp-1:0] twid;
    logic [31:0]              pc;
    logic [31:0]              data;
  } entry_t;

  typedef struct packed {
    logic                     kill;
    logic [twid_width_lp-1:0] twid;
    logic [31:0]              pc;
  } tag_t;

  logic [31:0]              pc_q [NUM_THREADS_P];
  logic [twid_width_lp-1:0] rr_ptr_q;
  logic                     req_vld_q;
  logic [twid_width_lp-1:0] req_twid_q;
  logic [31:0]              req_addr_q;
  logic                     outst_q;
  tag_t                     tag_q;
  entry_t                   queue_q [QUEUE_DEPTH_P];
  logic [ptr_w_lp-1:0]      wr_ptr_q;
  logic [ptr_w_lp-1:0]      rd_ptr_q;

  logic [31:0]              redir_pc;
  logic                     req_fire;
  logic                     rsp_fire;
  logic                     pop;
  logic                     q_empty;
  logic [ptr_w_lp-1:0]      q_count;
  logic                     credit_ok;
  logic                     pick_vld;
  logic [twid_width_lp-1:0] pick_twid;
  logic [twid_width_lp-1:0] cand;
  logic                     issue;
  logic [31:0]              issue_addr;
  logic [twid_width_lp-1:0] rr_next;
  logic                     redir_req;
  logic                     redir_tag;
  logic                     redir_head;
  logic                     redir_pick;
  entry_t                   head;
  entry_t                   new_entry;

  assign redir_pc  = redirect_pc_i & ~32'h0000_0003;
  assign req_fire  = req_vld_q & imem_req_rdy_i;
  assign rsp_fire  = imem_rsp_vld_i & outst_q;
  assign q_empty   = (wr_ptr_q == rd_ptr_q);
  assign q_count   = wr_ptr_q - rd_ptr_q;
  assign credit_ok = ~outst_q & (q_count < ptr_w_lp'(QUEUE_DEPTH_P));

  assign head       = queue_q[rd_ptr_q[qaw_lp-1:0]];
  assign redir_head = redirect_vld_i & (redirect_twid_i == head.twid);
  assign redir_req  = redirect_vld_i & (redirect_twid_i == req_twid_q);
  assign redir_tag  = redirect_vld_i & (redirect_twid_i == tag_q.twid);
  assign redir_pick = redirect_vld_i & (redirect_twid_i == pick_twid);
  assign pop        = ~q_empty & (head.kill | (decode_rdy_i & insn_vld_o));

  // Round-robin: first enabled thread at or after rr_ptr
  always_comb begin
    pick_vld  = 1'b0;
    pick_twid = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_THREADS_P; i++) begin
      cand = twid_width_lp'((32'(rr_ptr_q) + i) % NUM_THREADS_P);
      if (!pick_vld && thread_en_i[cand]) begin
        pick_vld  = 1'b1;
        pick_twid = cand;
      end
    end
  end

  // A redirect landing in the issue cycle must not be lost to a stale PC
  assign issue      = ~req_vld_q & credit_ok & pick_vld;
  assign issue_addr = redir_pick ? redir_pc : pc_q[pick_twid];
  assign rr_next    = (req_twid_q == twid_width_lp'(NUM_THREADS_P - 1)) ? '0 : req_twid_q + 1'b1;

  always_comb begin
    new_entry         = '0;
    new_entry.kill    = tag_q.kill | redir_tag;
    new_entry.illegal = imem_rsp_err_i | (imem_rsp_data_i[1:0] != 2'b11);
    new_entry.twid    = tag_q.twid;
    new_entry.pc      = tag_q.pc;
    new_entry.data    = imem_rsp_data_i;
  end

  // Per-thread PCs; redirect wins over the post-accept increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned t = 0; t < NUM_THREADS_P; t++) pc_q[t] <= BOOT_PC_P;
    end else begin
      for (int unsigned t = 0; t < NUM_THREADS_P; t++) begin
        if (redirect_vld_i && redirect_twid_i == twid_width_lp'(t))
          pc_q[t] <= redir_pc;
        else if (req_fire && req_twid_q == twid_width_lp'(t))
          pc_q[t] <= pc_q[t] + 32'd4;
      end
    end
  end

  // Request handshake, outstanding tag and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_vld_q  <= 1'b0;
      req_twid_q <= '0;
      req_addr_q <= '0;
      outst_q    <= 1'b0;
      tag_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      if (req_vld_q) begin
        if (req_fire || redir_req) req_vld_q <= 1'b0;
      end else if (issue) begin
        req_vld_q  <= 1'b1;
        req_twid_q <= pick_twid;
        req_addr_q <= issue_addr;
      end
      if (req_fire) begin
        outst_q  <= 1'b1;
        tag_q    <= '{kill: redir_req, twid: req_twid_q, pc: req_addr_q};
        rr_ptr_q <= rr_next;
      end else if (rsp_fire) begin
        outst_q <= 1'b0;
      end else if (outst_q && redir_tag) begin
        tag_q.kill <= 1'b1;
      end
    end
  end

  // In-order instruction queue; redirected thread's entries are marked dead
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH_P; i++) queue_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      for (int unsigned i = 0; i < QUEUE_DEPTH_P; i++) begin
        if (redirect_vld_i && queue_q[i].twid == redirect_twid_i) queue_q[i].kill <= 1'b1;
      end
      if (rsp_fire) begin
        queue_q[wr_ptr_q[qaw_lp-1:0]] <= new_entry;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign imem_req_vld_o  = req_vld_q;
  assign imem_req_addr_o = req_addr_q;
  assign insn_vld_o      = ~q_empty & ~head.kill & ~redir_head;
  assign insn_o          = head.data;
  assign insn_pc_o       = head.pc;
  assign insn_twid_o     = head.twid;
  assign insn_is_rv16_o  = 1'b0;
  assign insn_illegal_o  = ~q_empty & head.illegal;

endmodule
